// File: rtl/telemetry_rx.sv
`default_nettype none
// ============================================================================
// telemetry_rx : 8N1 UART receiver and AA55-framed 8-byte telemetry decoder
// Rev 1.0 - initial release
// ============================================================================
module telemetry_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frm_err
);
  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] c_full    = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] c_half    = CW'(BAUD_DIV / 2 - 1);
  localparam logic [16:0]   c_timeout = 17'(TIMEOUT);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_st_t;
  typedef enum logic [1:0] {P_H1, P_H2, P_PAY} pkt_st_t;

  logic          r_rx_meta, r_rx_sync;
  byte_st_t      r_bst, w_bst_nxt;
  logic [CW-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          w_stop_ok, w_stop_bad;
  logic          r_byte_rdy;

  pkt_st_t       r_pst, w_pst_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [11:0]   r_sh_batt, w_sh_batt_nxt;
  logic [11:0]   r_sh_curr, w_sh_curr_nxt;
  logic [3:0]    r_sh_tq_hi, w_sh_tq_hi_nxt;
  logic          w_commit;
  logic          w_to_run, w_timeout;
  logic [16:0]   r_to_cnt;

  // Byte receiver: mid-bit sampling referenced to the synchronized start edge
  always_comb begin
    w_bst_nxt      = r_bst;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_stop_ok      = 1'b0;
    w_stop_bad     = 1'b0;
    case (r_bst)
      B_IDLE: begin
        if (!r_rx_sync) begin
          w_bst_nxt      = B_START;
          w_baud_cnt_nxt = '0;
        end
      end
      B_START: begin
        if (r_baud_cnt == c_half) begin
          w_baud_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
          w_bst_nxt      = r_rx_sync ? B_IDLE : B_DATA;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 1'b1;
        end
      end
      B_DATA: begin
        if (r_baud_cnt == c_full) begin
          w_baud_cnt_nxt = '0;
          w_shift_nxt    = {r_rx_sync, r_shift[7:1]};
          w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_bst_nxt = B_STOP;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 1'b1;
        end
      end
      B_STOP: begin
        if (r_baud_cnt == c_full) begin
          w_baud_cnt_nxt = '0;
          w_bst_nxt      = B_IDLE;
          w_stop_ok      = r_rx_sync;
          w_stop_bad     = !r_rx_sync;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 1'b1;
        end
      end
      default: w_bst_nxt = B_IDLE;
    endcase
  end

  assign w_to_run  = (r_pst != P_H1) && (r_bst == B_IDLE);
  assign w_timeout = w_to_run && !r_byte_rdy && (r_to_cnt >= c_timeout);

  // Payload byte 5 feeds torque directly at commit, so only five bytes are shadowed
  always_comb begin
    w_pst_nxt      = r_pst;
    w_idx_nxt      = r_idx;
    w_sh_batt_nxt  = r_sh_batt;
    w_sh_curr_nxt  = r_sh_curr;
    w_sh_tq_hi_nxt = r_sh_tq_hi;
    w_commit       = 1'b0;
    if (w_stop_bad || w_timeout) begin
      w_pst_nxt      = P_H1;
      w_sh_batt_nxt  = '0;
      w_sh_curr_nxt  = '0;
      w_sh_tq_hi_nxt = '0;
    end else if (r_byte_rdy) begin
      case (r_pst)
        P_H1: if (r_shift == 8'hAA) w_pst_nxt = P_H2;
        P_H2: begin
          if (r_shift == 8'h55) begin
            w_pst_nxt = P_PAY;
            w_idx_nxt = '0;
          end else if (r_shift != 8'hAA) begin
            w_pst_nxt = P_H1;
          end
        end
        P_PAY: begin
          w_idx_nxt = r_idx + 1'b1;
          case (r_idx)
            3'd0: w_sh_batt_nxt[11:8] = r_shift[3:0];
            3'd1: w_sh_batt_nxt[7:0]  = r_shift;
            3'd2: w_sh_curr_nxt[11:8] = r_shift[3:0];
            3'd3: w_sh_curr_nxt[7:0]  = r_shift;
            3'd4: w_sh_tq_hi_nxt      = r_shift[3:0];
            default: begin
              w_commit  = 1'b1;
              w_pst_nxt = P_H1;
            end
          endcase
        end
        default: w_pst_nxt = P_H1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_bst      <= B_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_rdy <= 1'b0;
      r_pst      <= P_H1;
      r_idx      <= '0;
      r_sh_batt  <= '0;
      r_sh_curr  <= '0;
      r_sh_tq_hi <= '0;
      r_to_cnt   <= '0;
      batt       <= '0;
      curr       <= '0;
      torque     <= '0;
      vld        <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      r_rx_meta  <= RX;
      r_rx_sync  <= r_rx_meta;
      r_bst      <= w_bst_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_rdy <= w_stop_ok;
      r_pst      <= w_pst_nxt;
      r_idx      <= w_idx_nxt;
      r_sh_batt  <= w_sh_batt_nxt;
      r_sh_curr  <= w_sh_curr_nxt;
      r_sh_tq_hi <= w_sh_tq_hi_nxt;
      vld        <= w_commit;
      frm_err    <= w_stop_bad | w_timeout;
      if (w_commit) begin
        batt   <= r_sh_batt;
        curr   <= r_sh_curr;
        torque <= {r_sh_tq_hi, r_shift};
      end
      if (r_byte_rdy || w_timeout || w_stop_bad || (r_pst == P_H1))
        r_to_cnt <= '0;
      else if (w_to_run)
        r_to_cnt <= r_to_cnt + 17'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_telemetry_rx.sv
`default_nettype none
// ============================================================================
// tb_telemetry_rx : directed self-checking bench for telemetry_rx
// Rev 1.0 - initial release
// ============================================================================
module tb_telemetry_rx;
  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic [11:0] batt, curr, torque;
  logic        vld, frm_err;

  int errors = 0;
  int checks = 0;
  int n_vld  = 0;
  int n_err  = 0;
  int n_rdy  = 0;
  int cyc    = 0;
  int last_err_cyc = 0;
  int v0, e0, r0, t0;

  telemetry_rx #(.BAUD_DIV(BAUD), .TIMEOUT(500)) dut (
    .clk(clk), .rst(rst), .RX(RX),
    .batt(batt), .curr(curr), .torque(torque),
    .vld(vld), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (vld) n_vld++;
    if (dut.r_byte_rdy) n_rdy++;
    if (frm_err) begin
      n_err++;
      last_err_cyc = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    RX = 1'b0;
    cycles(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      cycles(BAUD);
    end
    RX = stop;
    cycles(BAUD);
    RX = 1'b1;
  endtask

  task automatic send_pkt(input logic [63:0] p);
    for (int i = 0; i < 8; i++) send_byte(p[63-8*i -: 8]);
  endtask

  task automatic snap();
    v0 = n_vld;
    e0 = n_err;
    r0 = n_rdy;
  endtask

  initial begin
    RX  = 1'b1;
    rst = 1'b1;
    cycles(5);
    chk("rst_batt", 32'(batt), 0);
    chk("rst_curr", 32'(curr), 0);
    chk("rst_torque", 32'(torque), 0);
    chk("rst_vld", 32'(vld), 0);
    chk("rst_frm_err", 32'(frm_err), 0);
    rst = 1'b0;
    cycles(40);

    // basic packet
    snap();
    send_pkt(64'hAA550C3405670700);
    cycles(40);
    chk("t1_vld_cnt", n_vld - v0, 1);
    chk("t1_batt", 32'(batt), 32'hC34);
    chk("t1_curr", 32'(curr), 32'h567);
    chk("t1_torque", 32'(torque), 32'h700);
    chk("t1_err_cnt", n_err - e0, 0);

    // header resync, fully back-to-back
    snap();
    send_byte(8'hAA);
    send_pkt(64'hAA55012304560789);
    cycles(40);
    chk("t2_vld_cnt", n_vld - v0, 1);
    chk("t2_batt", 32'(batt), 32'h123);
    chk("t2_curr", 32'(curr), 32'h456);
    chk("t2_torque", 32'(torque), 32'h789);
    chk("t2_err_cnt", n_err - e0, 0);

    // stop-bit error in the 4th byte aborts the packet
    snap();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h0A);
    send_byte(8'hBC, 1'b0);
    cycles(48);
    send_byte(8'h0D);
    send_byte(8'hEF);
    send_byte(8'h0E);
    send_byte(8'h01);
    cycles(40);
    chk("t3_err_cnt", n_err - e0, 1);
    chk("t3_vld_cnt", n_vld - v0, 0);
    chk("t3_batt_hold", 32'(batt), 32'h123);
    chk("t3_curr_hold", 32'(curr), 32'h456);
    chk("t3_torque_hold", 32'(torque), 32'h789);
    send_pkt(64'hAA55032106540987);
    cycles(40);
    chk("t3b_vld_cnt", n_vld - v0, 1);
    chk("t3b_err_cnt", n_err - e0, 1);
    chk("t3b_batt", 32'(batt), 32'h321);
    chk("t3b_curr", 32'(curr), 32'h654);
    chk("t3b_torque", 32'(torque), 32'h987);

    // short glitch is a false start
    snap();
    RX = 1'b0;
    cycles(BAUD / 4);
    RX = 1'b1;
    cycles(60);
    chk("t4_rdy_cnt", n_rdy - r0, 0);
    chk("t4_vld_cnt", n_vld - v0, 0);
    chk("t4_err_cnt", n_err - e0, 0);

    // inter-byte timeout after a partial packet
    snap();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h0F);
    t0 = cyc;
    cycles(600);
    chk("t5_err_cnt", n_err - e0, 1);
    chk("t5_vld_cnt", n_vld - v0, 0);
    chk("t5_err_delay_ok", 32'((last_err_cyc - t0 >= 470) && (last_err_cyc - t0 <= 530)), 1);
    send_pkt(64'hAA550ABC0DEF0E01);
    cycles(40);
    chk("t5b_vld_cnt", n_vld - v0, 1);
    chk("t5b_batt", 32'(batt), 32'hABC);
    chk("t5b_curr", 32'(curr), 32'hDEF);
    chk("t5b_torque", 32'(torque), 32'hE01);

    // asynchronous reset in the middle of byte 6
    snap();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    RX = 1'b0;
    cycles(BAUD);
    RX = 1'b1;
    cycles(2 * BAUD);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_batt", 32'(batt), 0);
    chk("t6_rst_curr", 32'(curr), 0);
    chk("t6_rst_torque", 32'(torque), 0);
    chk("t6_rst_vld", 32'(vld), 0);
    chk("t6_rst_frm_err", 32'(frm_err), 0);
    cycles(3);
    rst = 1'b0;
    cycles(40);
    send_pkt(64'hAA550FFF08000123);
    cycles(40);
    chk("t6_vld_cnt", n_vld - v0, 1);
    chk("t6_err_cnt", n_err - e0, 0);
    chk("t6_batt", 32'(batt), 32'hFFF);
    chk("t6_curr", 32'(curr), 32'h800);
    chk("t6_torque", 32'(torque), 32'h123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/telemetry_rx.md
# telemetry_rx

Bench-side and board-side receiver for the eBike serial telemetry stream driven on the `TX` pin. It deserializes 8N1 UART bytes, frames them into fixed 8-byte telemetry packets, and presents the decoded 12-bit battery, current and torque readings with a one-cycle valid strobe. It sits on the far end of the `TX` line. It is the checker the top-level bench uses to compare transmitted telemetry against the analog model inputs.

## Interface

**Parameters**
- `BAUD_DIV`, default 2604: clocks per bit (50 MHz / 19200 baud). Must be ≥ 8.
- `TIMEOUT`, default 65535: idle clocks allowed between bytes of one packet before the packet is abandoned.

**Ports** (clock and reset first)
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `RX`, input, 1: serial line, idle high, asynchronous to `clk`.
- `batt`, output, 12: last valid battery reading.
- `curr`, output, 12: last valid current reading.
- `torque`, output, 12: last valid torque reading.
- `vld`, output, 1: one-cycle pulse when `batt`/`curr`/`torque` update.
- `frm_err`, output, 1: one-cycle pulse on a stop-bit error or a packet timeout.

## Operation

**Packet format**, bytes in order:
- 0xAA, 0x55 (header)
- `{4'h0,BATT[11:8]}`, `BATT[7:0]`
- `{4'h0,CURR[11:8]}`, `CURR[7:0]`
- `{4'h0,TORQUE[11:8]}`, `TORQUE[7:0]`
- Upper nibbles of the hi bytes are ignored on receive.

**RX front end**
- Two-flop synchronizer on `RX`. All logic below uses the synchronized value.

**Byte receiver FSM**
- `IDLE`: wait for synchronized `RX` = 0.
- `START`: count `BAUD_DIV/2` clocks, then sample. If the sample is 1, it is a false start; return to `IDLE` with no output.
- `DATA`: sample every `BAUD_DIV` clocks, 8 bits, LSB first, shifted into `rx_byte`.
- `STOP`: sample after `BAUD_DIV` clocks.
  - Sample = 1: pulse internal `byte_rdy`.
  - Sample = 0: pulse `frm_err`, drop the byte, return to `IDLE`. A framing error also forces the packet FSM to `H1`.

**Packet FSM** (advances only on `byte_rdy`)
- `H1`: byte 0xAA goes to `H2`; any other byte stays in `H1`.
- `H2`: 0x55 goes to `PAY` with index 0. 0xAA stays in `H2` (resync). Any other byte goes to `H1`.
- `PAY`: store the byte at the 3-bit index into a 6-byte shadow register. After index 5, go to `H1` and assert the commit.

**Commit**
- `batt`, `curr`, `torque` load from the shadow in the same edge, and `vld` = 1 for exactly that one cycle.
- Outputs hold until the next commit.

**Timeout**
- A 17-bit counter runs while the packet FSM is in `H2` or `PAY` and the byte FSM is in `IDLE`. It clears on every `byte_rdy`.
- On reaching `TIMEOUT`: pulse `frm_err`, go to `H1`, and discard partial shadow data. Shadow contents are not committed.

**Simultaneous events**
- A framing error and a timeout in the same cycle give a single `frm_err` pulse.
- `byte_rdy` has priority over the timeout compare.

## Timing

**Reset values** (`rst` = 1): `batt`, `curr`, `torque` = 0; `vld` = 0; `frm_err` = 0; byte FSM `IDLE`; packet FSM `H1`; counters 0; synchronizer flops 1.

**Reset mid-operation**
- Asynchronous reset aborts any byte or packet in progress. No `vld` is issued.
- After `rst` falls, the first byte is received correctly only if its start edge comes after release.

**Latency**
- Synchronizer: 2 clocks.
- Stop-bit sample: 2 + `BAUD_DIV/2` + 9·`BAUD_DIV` clocks after the start-bit falling edge, ±1.
- `byte_rdy`: asserted the clock after the stop sample.
- `vld`: asserted the clock after the `byte_rdy` of the 8th byte.
- `frm_err`: asserted the clock after the bad stop sample, or the clock after the timeout compare.

**Bit sampling**
- Sampling is at mid-bit. Tolerates ±4% baud mismatch over 10 bits.
- Back-to-back bytes with zero idle time between the stop bit and the next start bit must be received.
- The next start bit is detected from `IDLE` on the clock after the stop sample.

## Test plan

1. `BAUD_DIV`=16. Send AA 55 0C 34 05 67 07 00 -> exactly one `vld` pulse with `batt`=0xC34, `curr`=0x567, `torque`=0x700. `frm_err` never asserts.
2. Send AA AA 55 01 23 04 56 07 89, back-to-back with no idle -> resync in `H2`. One `vld` with `batt`=0x123, `curr`=0x456, `torque`=0x789.
3. Valid packet, then a packet whose 4th byte has stop bit = 0 -> one `frm_err` pulse, no second `vld`, outputs keep their first values. A following valid packet updates normally.
4. Glitch `RX` low for `BAUD_DIV/4` clocks -> false start rejected; no `byte_rdy`, `vld` or `frm_err`.
5. `TIMEOUT`=500. Send AA 55 0F, then hold `RX` high for 600 clocks -> `frm_err` pulses once about 500 clocks after that byte, no `vld`. A fresh packet then decodes correctly.
6. Assert `rst` mid-way through byte 6 -> all outputs 0 immediately. After release, a full packet yields `vld` with correct values.
